// File: rtl/player_move_ctrl.sv
// Tile-grid sprite mover: queries the map for the target tile, then walks 32 pixels at STEP_DIV clocks per pixel.
// Optional build macro PLAYER_GOAL_EN adds a one-cycle goal pulse on arrival at a tile of type 3'b011.
module player_move_ctrl #(
  parameter int          START_ROW = 1,
  parameter int          START_COL = 1,
  parameter int          STEP_DIV  = 64,
  parameter logic [2:0]  WALL_TYPE = 3'b010
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       tq_valid,
  output logic [3:0] tq_row,
  output logic [4:0] tq_col,
  input  logic       tq_ready,
  input  logic [2:0] tq_type,
  output logic [9:0] pos_r,
  output logic [9:0] pos_c,
  output logic [2:0] move_stat,
  output logic       anim_frame,
  output logic       busy,
  output logic       goal
);

  // state | meaning
  // IDLE  | waiting for a button, tile position stable
  // QUERY | tq_valid high, waiting for the map answer
  // WALK  | stepping one pixel every STEP_DIV clocks, 32 steps
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_QUERY = 2'd1;
  localparam logic [1:0] S_WALK  = 2'd2;

  localparam logic [2:0] DIR_STOP  = 3'd0;
  localparam logic [2:0] DIR_DOWN  = 3'd1;
  localparam logic [2:0] DIR_UP    = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_RIGHT = 3'd4;

  localparam logic [9:0] DIV_LAST = 10'(STEP_DIV - 1);

  logic [1:0] state;
  logic [2:0] dir;
  logic [3:0] tile_row, q_row, tgt_row;
  logic [4:0] tile_col, q_col, tgt_col;
  logic [9:0] div_cnt;
  logic [4:0] step_cnt;
  logic [2:0] req_dir;
  logic       tgt_ok;
  logic       step_tick;
  logic       walk_done;

  always_comb begin
    req_dir = DIR_STOP;
    if (btn_up)         req_dir = DIR_UP;
    else if (btn_down)  req_dir = DIR_DOWN;
    else if (btn_left)  req_dir = DIR_LEFT;
    else if (btn_right) req_dir = DIR_RIGHT;
  end

  // Off-grid targets are rejected here so no query is ever issued for them.
  always_comb begin
    tgt_row = tile_row;
    tgt_col = tile_col;
    tgt_ok  = 1'b0;
    case (req_dir)
      DIR_UP: begin
        tgt_row = tile_row - 4'd1;
        tgt_ok  = (tile_row != 4'd0);
      end
      DIR_DOWN: begin
        tgt_row = tile_row + 4'd1;
        tgt_ok  = (tile_row != 4'd9);
      end
      DIR_LEFT: begin
        tgt_col = tile_col - 5'd1;
        tgt_ok  = (tile_col != 5'd0);
      end
      DIR_RIGHT: begin
        tgt_col = tile_col + 5'd1;
        tgt_ok  = (tile_col != 5'd19);
      end
      default: tgt_ok = 1'b0;
    endcase
  end

  assign step_tick = (state == S_WALK) && (div_cnt == DIV_LAST);
  assign walk_done = step_tick && (step_cnt == 5'd31);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      dir      <= DIR_STOP;
      tile_row <= 4'(START_ROW);
      tile_col <= 5'(START_COL);
      q_row    <= 4'(START_ROW);
      q_col    <= 5'(START_COL);
      div_cnt  <= '0;
      step_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (tgt_ok) begin
            state <= S_QUERY;
            dir   <= req_dir;
            q_row <= tgt_row;
            q_col <= tgt_col;
          end
        end
        S_QUERY: begin
          if (tq_ready) begin
            div_cnt  <= '0;
            step_cnt <= '0;
            state    <= (tq_type == WALL_TYPE) ? S_IDLE : S_WALK;
          end
        end
        S_WALK: begin
          if (step_tick) begin
            div_cnt  <= '0;
            step_cnt <= step_cnt + 5'd1;
            if (walk_done) begin
              state    <= S_IDLE;
              tile_row <= q_row;
              tile_col <= q_col;
            end
          end else begin
            div_cnt <= div_cnt + 10'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [9:0] base_r, base_c, offs;
  assign base_r = {1'b0, tile_row, 5'b0};
  assign base_c = {tile_col, 5'b0};
  assign offs   = {5'b0, step_cnt};

  always_comb begin
    pos_r = base_r;
    pos_c = base_c;
    if (state == S_WALK) begin
      case (dir)
        DIR_DOWN:  pos_r = base_r + offs;
        DIR_UP:    pos_r = base_r - offs;
        DIR_RIGHT: pos_c = base_c + offs;
        DIR_LEFT:  pos_c = base_c - offs;
        default:   pos_r = base_r;
      endcase
    end
  end

  assign tq_valid   = (state == S_QUERY);
  assign tq_row     = q_row;
  assign tq_col     = q_col;
  assign busy       = (state != S_IDLE);
  assign move_stat  = busy ? dir : DIR_STOP;
  assign anim_frame = (state == S_WALK) & step_cnt[3];

`ifdef PLAYER_GOAL_EN
  logic [2:0] type_q;
  logic       goal_q;

  // Registered so the pulse lands in the first IDLE cycle after the walk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      type_q <= '0;
      goal_q <= 1'b0;
    end else begin
      if (state == S_QUERY && tq_ready) type_q <= tq_type;
      goal_q <= walk_done && (type_q == 3'b011);
    end
  end

  assign goal = goal_q;
`else
  assign goal = 1'b0;
`endif

endmodule
